// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
// Multicycle control unit: sequences fetch / decode / execute / memory /
// writeback from the IR opcode. It handles a variable-latency memory handshake
// with a timeout, qualifies branches, provides HALT/TRAP states that are left
// through i_resume, and keeps wrap-around cycle and retired-instruction
// counters.
//
// Ports
//   i_clk           rising-edge clock
//   i_rst           asynchronous active-high reset
//   i_opcode[5:0]   IR opcode (valid from the cycle after o_ir_write)
//   i_mem_ready     memory completes the current request this cycle
//   i_branch_cond   ALU branch condition, used in BRANCH3
//   i_resume        leave HALT/TRAP
//   o_state[3:0]    current state encoding
//   o_mem_read      memory read request
//   o_mem_write     memory write request
//   o_ir_write      latch IR
//   o_pc_write      PC update enable
//   o_reg_write     register file write enable
//   o_instr_done    one-cycle retire pulse
//   o_halted        state is HALT
//   o_trap          state is TRAP
//   o_trap_cause    00 none, 01 illegal opcode, 10 memory timeout, 11 bad state
//   o_cycle_count   cycles spent outside HALT/TRAP
//   o_instr_count   retired instructions
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter int WAIT_W      = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [5:0]       i_opcode,
    input  logic             i_mem_ready,
    input  logic             i_branch_cond,
    input  logic             i_resume,
    output logic [3:0]       o_state,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic             o_ir_write,
    output logic             o_pc_write,
    output logic             o_reg_write,
    output logic             o_instr_done,
    output logic             o_halted,
    output logic             o_trap,
    output logic [1:0]       o_trap_cause,
    output logic [CNT_W-1:0] o_cycle_count,
    output logic [CNT_W-1:0] o_instr_count
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_IMM2    = 4'd2,
        S_ALU_R3  = 4'd3,
        S_ALU_RI3 = 4'd4,
        S_ALU4    = 4'd5,
        S_BRANCH3 = 4'd6,
        S_MEM3    = 4'd7,
        S_LOAD4   = 4'd8,
        S_LOAD5   = 4'd9,
        S_STORE4  = 4'd10,
        S_JUMP3   = 4'd11,
        S_HALT    = 4'd12,
        S_TRAP    = 4'd13
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
    localparam logic [1:0] CAUSE_BADST   = 2'b11;

    // A zero MEM_TIMEOUT disables the deadline entirely.
    localparam bit                TIMEOUT_EN = (MEM_TIMEOUT > 0);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = TIMEOUT_EN ? WAIT_W'(MEM_TIMEOUT - 1) : {WAIT_W{1'b0}};
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    state_t            r_state;
    state_t            w_next_state;
    logic [1:0]        r_trap_cause;
    logic [1:0]        w_next_cause;
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_next_wait;
    logic [CNT_W-1:0]  r_cycle_count;
    logic [CNT_W-1:0]  r_instr_count;
    logic              w_mem_state;
    logic              w_timeout;
    logic              w_instr_done;
    logic              w_stopped;

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_LOAD4) || (r_state == S_STORE4);
    // Deadline hit only when memory is still not ready; a late ready wins.
    assign w_timeout   = TIMEOUT_EN && !i_mem_ready && (r_wait == WAIT_LIMIT);
    assign w_stopped   = (r_state == S_HALT) || (r_state == S_TRAP);
    assign w_instr_done = (r_state == S_IMM2) || (r_state == S_ALU4) || (r_state == S_BRANCH3) ||
                          (r_state == S_JUMP3) || (r_state == S_LOAD5) ||
                          ((r_state == S_STORE4) && i_mem_ready);

    // State, trap cause and memory wait counter registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_FETCH;
            r_trap_cause <= CAUSE_NONE;
            r_wait       <= {WAIT_W{1'b0}};
        end else begin
            r_state      <= w_next_state;
            r_trap_cause <= w_next_cause;
            r_wait       <= w_next_wait;
        end
    end

    // Next-state, trap-cause and wait-counter logic.
    always_comb begin
        w_next_state = r_state;
        w_next_cause = r_trap_cause;
        w_next_wait  = {WAIT_W{1'b0}};
        case (r_state)
            S_FETCH: begin
                if (i_mem_ready) begin
                    w_next_state = S_DECODE;
                end else if (w_timeout) begin
                    w_next_state = S_TRAP;
                    w_next_cause = CAUSE_TIMEOUT;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_DECODE: begin
                casez (i_opcode)
                    6'b00????: w_next_state = S_ALU_R3;
                    6'b01????: w_next_state = S_ALU_RI3;
                    6'b100???: w_next_state = S_BRANCH3;
                    6'b101???: w_next_state = S_MEM3;
                    6'b110???: w_next_state = S_JUMP3;
                    6'b111000: w_next_state = S_IMM2;
                    6'b111111: w_next_state = S_HALT;
                    default: begin
                        w_next_state = S_TRAP;
                        w_next_cause = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_ALU_R3, S_ALU_RI3: w_next_state = S_ALU4;
            S_ALU4, S_IMM2, S_BRANCH3, S_JUMP3, S_LOAD5: w_next_state = S_FETCH;
            S_MEM3: w_next_state = i_opcode[2] ? S_STORE4 : S_LOAD4;
            S_LOAD4, S_STORE4: begin
                if (i_mem_ready) begin
                    w_next_state = (r_state == S_LOAD4) ? S_LOAD5 : S_FETCH;
                end else if (w_timeout) begin
                    w_next_state = S_TRAP;
                    w_next_cause = CAUSE_TIMEOUT;
                end else begin
                    w_next_state = r_state;
                end
            end
            S_HALT, S_TRAP: begin
                if (i_resume) begin
                    w_next_state = S_FETCH;
                    w_next_cause = CAUSE_NONE;
                end else begin
                    w_next_state = r_state;
                end
            end
            default: begin
                w_next_state = S_TRAP;
                w_next_cause = CAUSE_BADST;
            end
        endcase
        // Only an uninterrupted stall counts; any transition or ready clears it.
        if (w_mem_state && !i_mem_ready && (w_next_state == r_state)) begin
            w_next_wait = r_wait + WAIT_ONE;
        end else begin
            w_next_wait = {WAIT_W{1'b0}};
        end
    end

    // Performance counters, frozen while halted or trapped.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cycle_count <= {CNT_W{1'b0}};
            r_instr_count <= {CNT_W{1'b0}};
        end else begin
            if (!w_stopped) begin
                r_cycle_count <= r_cycle_count + CNT_ONE;
            end
            if (w_instr_done) begin
                r_instr_count <= r_instr_count + CNT_ONE;
            end
        end
    end

    assign o_state       = r_state;
    assign o_mem_read    = (r_state == S_FETCH) || (r_state == S_LOAD4);
    assign o_mem_write   = (r_state == S_STORE4);
    assign o_ir_write    = (r_state == S_FETCH) && i_mem_ready;
    assign o_pc_write    = ((r_state == S_FETCH) && i_mem_ready) || (r_state == S_JUMP3) ||
                           ((r_state == S_BRANCH3) && i_branch_cond);
    assign o_reg_write   = (r_state == S_IMM2) || (r_state == S_ALU4) || (r_state == S_LOAD5);
    assign o_instr_done  = w_instr_done;
    assign o_halted      = (r_state == S_HALT);
    assign o_trap        = (r_state == S_TRAP);
    assign o_trap_cause  = r_trap_cause;
    assign o_cycle_count = r_cycle_count;
    assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
// Directed bench for multicycle_control_fsm (CNT_W=8, MEM_TIMEOUT=4).
// Each cycle the control outputs are packed as
//   {state[3:0], mem_read, mem_write, ir_write, pc_write, reg_write,
//    instr_done, halted, trap}
// and compared with hand-computed vectors.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

    logic       clk;
    logic       i_rst;
    logic [5:0] i_opcode;
    logic       i_mem_ready;
    logic       i_branch_cond;
    logic       i_resume;
    logic [3:0] o_state;
    logic       o_mem_read, o_mem_write, o_ir_write, o_pc_write, o_reg_write;
    logic       o_instr_done, o_halted, o_trap;
    logic [1:0] o_trap_cause;
    logic [7:0] o_cycle_count;
    logic [7:0] o_instr_count;
    logic [11:0] obs;

    int n_vec = 0;
    int n_err = 0;

    multicycle_control_fsm #(.CNT_W(8), .MEM_TIMEOUT(4), .WAIT_W(8)) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_opcode      (i_opcode),
        .i_mem_ready   (i_mem_ready),
        .i_branch_cond (i_branch_cond),
        .i_resume      (i_resume),
        .o_state       (o_state),
        .o_mem_read    (o_mem_read),
        .o_mem_write   (o_mem_write),
        .o_ir_write    (o_ir_write),
        .o_pc_write    (o_pc_write),
        .o_reg_write   (o_reg_write),
        .o_instr_done  (o_instr_done),
        .o_halted      (o_halted),
        .o_trap        (o_trap),
        .o_trap_cause  (o_trap_cause),
        .o_cycle_count (o_cycle_count),
        .o_instr_count (o_instr_count)
    );

    assign obs = {o_state, o_mem_read, o_mem_write, o_ir_write, o_pc_write,
                  o_reg_write, o_instr_done, o_halted, o_trap};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset, then releases it on a falling edge.
    task automatic do_reset();
        i_rst = 1'b1;
        i_mem_ready = 1'b0;
        i_resume = 1'b0;
        i_branch_cond = 1'b0;
        @(negedge clk);
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_opcode = 6'b000000;
        i_mem_ready = 1'b0;
        i_branch_cond = 1'b0;
        i_resume = 1'b0;
        #1;
        n_vec++;
        if (obs !== {4'd0, 8'b10000000}) begin
            $display("FAIL reset_outputs: got %h expected %h", obs, {4'd0, 8'b10000000}); n_err++;
        end
        n_vec++;
        if ({o_cycle_count, o_instr_count, o_trap_cause} !== 18'd0) begin
            $display("FAIL reset_counters: got cyc=%0d ins=%0d cause=%0d expected 0", o_cycle_count, o_instr_count, o_trap_cause); n_err++;
        end
        i_mem_ready = 1'b1;
        step();
        n_vec++;
        if (o_state !== 4'd0 || o_cycle_count !== 8'd0) begin
            $display("FAIL reset_held: got state=%0d cyc=%0d expected 0/0", o_state, o_cycle_count); n_err++;
        end
        @(negedge clk);
        i_rst = 1'b0;
    endtask

    task automatic test_alu();
        logic [11:0] ev [0:3];
        ev = '{{4'd0, 8'b10110000}, {4'd1, 8'b00000000}, {4'd3, 8'b00000000}, {4'd5, 8'b00001100}};
        do_reset();
        i_opcode = 6'b000010;
        i_mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++;
            if (obs !== ev[i]) begin
                $display("FAIL alu_cycle%0d: got %h expected %h", i, obs, ev[i]); n_err++;
            end
            step();
        end
        #1;
        n_vec++;
        if (o_state !== 4'd0 || o_instr_count !== 8'd1 || o_cycle_count !== 8'd4) begin
            $display("FAIL alu_retire: got state=%0d ins=%0d cyc=%0d expected 0/1/4", o_state, o_instr_count, o_cycle_count); n_err++;
        end
    endtask

    task automatic test_load();
        logic [11:0] ev [0:7];
        logic [7:0]  mr;
        ev = '{{4'd0, 8'b10110000}, {4'd1, 8'b00000000}, {4'd7, 8'b00000000}, {4'd8, 8'b10000000},
               {4'd8, 8'b10000000}, {4'd8, 8'b10000000}, {4'd8, 8'b10000000}, {4'd9, 8'b00001100}};
        mr = 8'b11000111;
        do_reset();
        i_opcode = 6'b101000;
        for (int i = 0; i < 8; i++) begin
            i_mem_ready = mr[i];
            #1;
            n_vec++;
            if (obs !== ev[i]) begin
                $display("FAIL load_cycle%0d: got %h expected %h", i, obs, ev[i]); n_err++;
            end
            step();
        end
        i_mem_ready = 1'b0;
        #1;
        n_vec++;
        if (obs !== {4'd0, 8'b10000000} || o_instr_count !== 8'd1 || o_cycle_count !== 8'd8) begin
            $display("FAIL load_retire: got obs=%h ins=%0d cyc=%0d expected 080/1/8", obs, o_instr_count, o_cycle_count); n_err++;
        end
    endtask

    task automatic test_store();
        logic [11:0] ev [0:4];
        logic [4:0]  mr;
        ev = '{{4'd0, 8'b10110000}, {4'd1, 8'b00000000}, {4'd7, 8'b00000000},
               {4'd10, 8'b01000000}, {4'd10, 8'b01000100}};
        mr = 5'b10111;
        do_reset();
        i_opcode = 6'b101100;
        for (int i = 0; i < 5; i++) begin
            i_mem_ready = mr[i];
            #1;
            n_vec++;
            if (obs !== ev[i]) begin
                $display("FAIL store_cycle%0d: got %h expected %h", i, obs, ev[i]); n_err++;
            end
            step();
        end
        #1;
        n_vec++;
        if (o_state !== 4'd0 || o_instr_count !== 8'd1 || o_cycle_count !== 8'd5) begin
            $display("FAIL store_retire: got state=%0d ins=%0d cyc=%0d expected 0/1/5", o_state, o_instr_count, o_cycle_count); n_err++;
        end
    endtask

    task automatic test_branch();
        logic [11:0] ev [0:2];
        do_reset();
        i_opcode = 6'b100000;
        i_mem_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            ev = '{{4'd0, 8'b10110000}, {4'd1, 8'b00000000}, {4'd6, 8'b00000100}};
            if (r == 1) ev[2] = {4'd6, 8'b00010100};
            i_branch_cond = r[0];
            for (int i = 0; i < 3; i++) begin
                #1;
                n_vec++;
                if (obs !== ev[i]) begin
                    $display("FAIL branch_run%0d_cycle%0d: got %h expected %h", r, i, obs, ev[i]); n_err++;
                end
                step();
            end
        end
        #1;
        n_vec++;
        if (o_state !== 4'd0 || o_instr_count !== 8'd2 || o_cycle_count !== 8'd6) begin
            $display("FAIL branch_retire: got state=%0d ins=%0d cyc=%0d expected 0/2/6", o_state, o_instr_count, o_cycle_count); n_err++;
        end
    endtask

    task automatic test_jump_ldi();
        logic [11:0] ev [0:5];
        logic [5:0]  op [0:5];
        ev = '{{4'd0, 8'b10110000}, {4'd1, 8'b00000000}, {4'd11, 8'b00010100},
               {4'd0, 8'b10110000}, {4'd1, 8'b00000000}, {4'd2, 8'b00001100}};
        op = '{6'b110000, 6'b110000, 6'b110000, 6'b111000, 6'b111000, 6'b111000};
        do_reset();
        i_mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            i_opcode = op[i];
            #1;
            n_vec++;
            if (obs !== ev[i]) begin
                $display("FAIL jump_ldi_cycle%0d: got %h expected %h", i, obs, ev[i]); n_err++;
            end
            step();
        end
        #1;
        n_vec++;
        if (o_instr_count !== 8'd2 || o_cycle_count !== 8'd6) begin
            $display("FAIL jump_ldi_counts: got ins=%0d cyc=%0d expected 2/6", o_instr_count, o_cycle_count); n_err++;
        end
    endtask

    task automatic test_trap_resume();
        do_reset();
        i_opcode = 6'b111010;
        i_mem_ready = 1'b1;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (obs !== {4'd13, 8'b00000001} || o_trap_cause !== 2'b01 ||
                o_cycle_count !== 8'd2 || o_instr_count !== 8'd0) begin
                $display("FAIL trap_hold%0d: got obs=%h cause=%0d cyc=%0d ins=%0d expected d01/1/2/0",
                         i, obs, o_trap_cause, o_cycle_count, o_instr_count); n_err++;
            end
            step();
        end
        i_resume = 1'b1;
        step();
        i_mem_ready = 1'b0;
        #1;
        n_vec++;
        if (o_state !== 4'd0 || o_trap_cause !== 2'b00 || o_cycle_count !== 8'd2) begin
            $display("FAIL trap_resume: got state=%0d cause=%0d cyc=%0d expected 0/0/2", o_state, o_trap_cause, o_cycle_count); n_err++;
        end
        step();
        n_vec++;
        if (o_state !== 4'd0 || o_cycle_count !== 8'd3) begin
            $display("FAIL resume_in_fetch: got state=%0d cyc=%0d expected 0/3", o_state, o_cycle_count); n_err++;
        end
        i_resume = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        i_opcode = 6'b000010;
        i_mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++;
            if (obs !== {4'd0, 8'b10000000}) begin
                $display("FAIL timeout_wait%0d: got %h expected %h", i, obs, {4'd0, 8'b10000000}); n_err++;
            end
            step();
        end
        #1;
        n_vec++;
        if (obs !== {4'd13, 8'b00000001} || o_trap_cause !== 2'b10 || o_cycle_count !== 8'd4) begin
            $display("FAIL timeout_trap: got obs=%h cause=%0d cyc=%0d expected d01/2/4", obs, o_trap_cause, o_cycle_count); n_err++;
        end
        do_reset();
        i_opcode = 6'b000010;
        for (int i = 0; i < 4; i++) begin
            i_mem_ready = (i == 3) ? 1'b1 : 1'b0;
            step();
        end
        #1;
        n_vec++;
        if (o_state !== 4'd1 || o_trap !== 1'b0 || o_trap_cause !== 2'b00) begin
            $display("FAIL deadline_ready: got state=%0d trap=%0d cause=%0d expected 1/0/0", o_state, o_trap, o_trap_cause); n_err++;
        end
    endtask

    task automatic test_halt_async_reset();
        do_reset();
        i_opcode = 6'b111111;
        i_mem_ready = 1'b1;
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            #1;
            n_vec++;
            if (obs !== {4'd12, 8'b00000010} || o_cycle_count !== 8'd2 || o_instr_count !== 8'd0) begin
                $display("FAIL halt_hold%0d: got obs=%h cyc=%0d ins=%0d expected c02/2/0", i, obs, o_cycle_count, o_instr_count); n_err++;
            end
            step();
        end
        i_resume = 1'b1;
        step();
        i_resume = 1'b0;
        i_opcode = 6'b101000;
        step();
        step();
        step();
        i_mem_ready = 1'b0;
        #1;
        n_vec++;
        if (obs !== {4'd8, 8'b10000000}) begin
            $display("FAIL halt_to_load4: got %h expected %h", obs, {4'd8, 8'b10000000}); n_err++;
        end
        #1;
        i_rst = 1'b1;
        #1;
        n_vec++;
        if (obs !== {4'd0, 8'b10000000} || o_cycle_count !== 8'd0 || o_instr_count !== 8'd0) begin
            $display("FAIL async_reset: got obs=%h cyc=%0d ins=%0d expected 080/0/0", obs, o_cycle_count, o_instr_count); n_err++;
        end
        @(negedge clk);
        i_rst = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        i_opcode = 6'b000010;
        i_mem_ready = 1'b1;
        repeat (256) step();
        #1;
        n_vec++;
        if (o_state !== 4'd0 || o_cycle_count !== 8'd0 || o_instr_count !== 8'd64) begin
            $display("FAIL counter_wrap: got state=%0d cyc=%0d ins=%0d expected 0/0/64", o_state, o_cycle_count, o_instr_count); n_err++;
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_branch();
        test_jump_ldi();
        test_trap_resume();
        test_timeout();
        test_halt_async_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
